riscv_trace_monitor: RTL and testbench
======================================

# riscv_trace_monitor

Synthesizable execution monitor for `riscv_soc` simulation and FPGA bring-up. It records taken jumps from the execute stage into a parametrised circular trace buffer, compressing repeated loop jumps. It also watches the register-file write port and produces a pass/fail verdict once the test-done register is written. It sits beside `riscv` inside `riscv_soc`, taps the jump-control and write-back signals, and is read out through a pop handshake.

## Interface
- `XLEN`, 32: address/data width.
- `DEPTH`, 16: trace entries; power of two, ≥2.
- `WRAP`, 1: 1 = overwrite oldest when full; 0 = drop new entry when full.
- `DONE_REG`, 26: register index whose write of 1 ends the test.
- `PASS_REG`, 27: register index holding 1 on pass.
- `TNUM_REG`, 3: register index holding the test number.
- `SETTLE`, 3: cycles from done-write to verdict; ≥1.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `jump_en` in 1: taken jump/branch this cycle.
- `jump_src` in XLEN: PC of the jumping instruction (execute stage).
- `jump_dst` in XLEN: jump target.
- `wb_en` in 1: register write enable.
- `wb_addr` in 5: register write index.
- `wb_data` in XLEN: register write data.
- `tr_pop` in 1: consume head entry.
- `tr_valid` out 1: buffer non-empty.
- `tr_src`, `tr_dst` out XLEN: head entry addresses.
- `tr_rpt` out 8: head entry extra repeat count.
- `tr_count` out log2(DEPTH)+1: entries held.
- `ovf_count` out 16: lost/overwritten entries, saturating.
- `done` out 1: verdict reached.
- `pass` out 1: verdict is pass.
- `testnum` out XLEN: TNUM_REG shadow at verdict.

## Operation
- Reset: buffer empty, all outputs 0, FSM in RUN, shadows 0.
- Shadows: on `wb_en` with `wb_addr`≠0 matching DONE_REG/PASS_REG/TNUM_REG, the matching shadow takes `wb_data`. Shadows update in RUN and SETTLE only.
- Capture happens in RUN and SETTLE only, and is frozen after the verdict. A pop after the verdict still works.
- Compression: a jump matches when its `jump_src`/`jump_dst` equal the newest entry. If it matches, the buffer is non-empty after any same-cycle pop, and that entry's rpt<255, increment rpt and write no new entry. If rpt is already 255, push a new entry with rpt=0.
- Push, not full: write at tail with rpt=0.
- Push, full, with `tr_pop`: accepted normally; count unchanged.
- Push, full, no pop, WRAP=1: overwrite oldest, advance head, `ovf_count`+1.
- Push, full, no pop, WRAP=0: drop the entry, `ovf_count`+1.
- `tr_pop` with empty buffer is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally.
- FSM:
  - RUN→SETTLE on a done-write with `wb_data`==1; load the settle counter with SETTLE−1.
  - SETTLE decrements the counter each cycle. At 0 it goes to PASS if the PASS shadow ==1, else FAIL. The verdict uses shadow values including a write in that same last cycle.
  - PASS and FAIL are terminal until `rst`.
  - A done-write with any other value is ignored.

## Timing
- Push or compression is visible on `tr_valid`/`tr_rpt`/`tr_count` one cycle after the `jump_en` edge.
- `tr_src`/`tr_dst`/`tr_rpt` are combinational reads of the head slot. A pop advances the head at the edge.
- `done`/`pass`/`testnum` go high exactly SETTLE+1 edges after the edge that samples the done-write. All three are registered.
- Asserting `rst` mid-SETTLE or after the verdict clears everything immediately, with no clock needed.

## Structure
- A shared header/package holds the FSM state encodings (RUN, SETTLE, PASS, FAIL), the entry width (2·XLEN+8), and the rpt saturation constant.
- Sub-module `trace_fifo`: circular buffer with push/pop/overwrite, a newest-entry read port, and a newest-entry rpt-increment port. Compression and the FSM live in the top.

## Test plan
- **Basic capture:** three distinct jumps (0x10→0x40, 0x48→0x10, 0x20→0x80), then pop ×3 → entries read in order with rpt=0, `tr_count` 3→0, `ovf_count`=0.
- **Loop compression:** 300 consecutive 0x30→0x20 jumps → two entries with rpt 255 and 43; `tr_count`=2.
- **Full buffer, WRAP=1 / DEPTH=4:** six distinct jumps → head is the 3rd jump, `ovf_count`=2.
- **Full buffer, WRAP=0:** same six jumps → head is the 1st jump, `ovf_count`=2.
- **Full buffer, push and pop together:** `tr_count` stays at DEPTH and `ovf_count` does not increment.
- **Pass verdict:** write x3=5, x27=1, then x26=1 → `done`=`pass`=1 with `testnum`=5 exactly 4 edges after the x26 write.
- **Fail verdict:** write x27=0 and x3=7, then x26=1, then x27=1 on the 3rd settle cycle → `pass`=1 (last-cycle write counts). Repeat with x27=0 throughout → `done`=1, `pass`=0, `testnum`=7.
- **Reset:** assert `rst` mid-SETTLE → all outputs 0 asynchronously; a subsequent run still passes.
- **Frozen after verdict:** jumps after `done` are not captured.

Source files
------------

// File: rtl/riscv_trace_monitor_pkg.sv
// Shared definitions for the jump-trace / verdict monitor: FSM encoding,
// trace entry layout and repeat-count saturation.
package riscv_trace_monitor_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_SETTLE, ST_PASS, ST_FAIL} mon_state_e;

  localparam int          RPT_W   = 8;
  localparam logic [7:0]  RPT_MAX = 8'd255;

  // Entry = {src, dst, rpt}; rpt in the low bits so the increment port is simple.
  function automatic int entry_w(input int xlen);
    return 2 * xlen + RPT_W;
  endfunction
endpackage

// File: rtl/riscv_trace_monitor_trace_fifo.sv
// Circular trace buffer: push/pop with optional overwrite-oldest when full,
// plus a read port and rpt-increment port on the newest entry.
module trace_fifo
  import riscv_trace_monitor_pkg::*;
#(
  parameter int  W     = 72,
  parameter int  DEPTH = 16,
  parameter int  WRAP  = 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          inc_rpt,
  output logic [W-1:0]  head_data,
  output logic [W-1:0]  newest_data,
  output logic          newest_valid,
  output logic [CW-1:0] count,
  output logic [15:0]   ovf_count
);
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           head_q, head_d, tail_q, tail_d, newest_idx;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [15:0]             ovf_q, ovf_d;
  logic                    pop_ok, full, lost;

  assign pop_ok       = pop && (cnt_q != '0);
  assign full         = (cnt_q == CW'(DEPTH));
  assign newest_idx   = tail_q - AW'(1);
  // Newest entry only counts if it survives a same-cycle pop.
  assign newest_valid = (cnt_q != '0) && !((cnt_q == CW'(1)) && pop_ok);
  assign head_data    = mem_q[head_q];
  assign newest_data  = mem_q[newest_idx];
  assign count        = cnt_q;
  assign ovf_count    = ovf_q;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    lost   = 1'b0;
    if (pop_ok) begin
      head_d = head_q + AW'(1);
      cnt_d  = cnt_q - CW'(1);
    end
    if (inc_rpt)
      mem_d[newest_idx][RPT_W-1:0] = mem_q[newest_idx][RPT_W-1:0] + RPT_W'(1);
    if (push) begin
      if (!full || pop_ok) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + AW'(1);
        cnt_d         = cnt_d + CW'(1);
      end else if (WRAP != 0) begin
        // Tail sits on the oldest slot when full: overwrite it and move head on.
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + AW'(1);
        head_d        = head_q + AW'(1);
        lost          = 1'b1;
      end else begin
        lost = 1'b1;
      end
    end
    if (lost && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end
endmodule

// File: rtl/riscv_trace_monitor.sv
// Execution monitor: compressed taken-jump trace plus a register-write
// driven pass/fail verdict with a settle window.
module riscv_trace_monitor
  import riscv_trace_monitor_pkg::*;
#(
  parameter int  XLEN     = 32,
  parameter int  DEPTH    = 16,
  parameter int  WRAP     = 1,
  parameter int  DONE_REG = 26,
  parameter int  PASS_REG = 27,
  parameter int  TNUM_REG = 3,
  parameter int  SETTLE   = 3,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_src,
  input  logic [XLEN-1:0] jump_dst,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            tr_pop,
  output logic            tr_valid,
  output logic [XLEN-1:0] tr_src,
  output logic [XLEN-1:0] tr_dst,
  output logic [7:0]      tr_rpt,
  output logic [CW-1:0]   tr_count,
  output logic [15:0]     ovf_count,
  output logic            done,
  output logic            pass,
  output logic [XLEN-1:0] testnum
);
  localparam int EW = entry_w(XLEN);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) + 1 : 1;

  mon_state_e      state_q, state_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [XLEN-1:0] pass_sh_q, pass_sh_d, tnum_sh_q, tnum_sh_d, testnum_q, testnum_d;
  logic            done_q, done_d, pass_q, pass_d;
  logic            cap, match, push, inc_rpt, newest_valid, wb_ok;
  logic [EW-1:0]   head_data, newest_data;

  assign cap   = (state_q == ST_RUN) || (state_q == ST_SETTLE);
  assign match = newest_valid && (newest_data[EW-1 -: XLEN] == jump_src)
                              && (newest_data[RPT_W +: XLEN] == jump_dst);
  assign wb_ok = cap && wb_en && (wb_addr != 5'd0);

  always_comb begin
    push    = 1'b0;
    inc_rpt = 1'b0;
    if (cap && jump_en) begin
      if (match && newest_data[RPT_W-1:0] != RPT_MAX) inc_rpt = 1'b1;
      else                                             push    = 1'b1;
    end
  end

  trace_fifo #(.W(EW), .DEPTH(DEPTH), .WRAP(WRAP)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_data   ({jump_src, jump_dst, 8'd0}),
    .pop         (tr_pop),
    .inc_rpt     (inc_rpt),
    .head_data   (head_data),
    .newest_data (newest_data),
    .newest_valid(newest_valid),
    .count       (tr_count),
    .ovf_count   (ovf_count)
  );

  assign tr_valid = (tr_count != '0);
  assign tr_src   = head_data[EW-1 -: XLEN];
  assign tr_dst   = head_data[RPT_W +: XLEN];
  assign tr_rpt   = head_data[RPT_W-1:0];

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    pass_sh_d = pass_sh_q;
    tnum_sh_d = tnum_sh_q;
    if (wb_ok && wb_addr == 5'(PASS_REG)) pass_sh_d = wb_data;
    if (wb_ok && wb_addr == 5'(TNUM_REG)) tnum_sh_d = wb_data;
    case (state_q)
      ST_RUN:
        if (wb_ok && wb_addr == 5'(DONE_REG) && wb_data == XLEN'(1)) begin
          state_d = ST_SETTLE;
          scnt_d  = SW'(SETTLE - 1);
        end
      ST_SETTLE:
        // Decide on the next-cycle shadow so a write in the final cycle counts.
        if (scnt_q == '0) state_d = (pass_sh_d == XLEN'(1)) ? ST_PASS : ST_FAIL;
        else              scnt_d  = scnt_q - SW'(1);
      default: state_d = state_q;
    endcase
    done_d    = (state_q == ST_PASS) || (state_q == ST_FAIL);
    pass_d    = (state_q == ST_PASS);
    testnum_d = done_d ? tnum_sh_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      scnt_q    <= '0;
      pass_sh_q <= '0;
      tnum_sh_q <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      testnum_q <= '0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      pass_sh_q <= pass_sh_d;
      tnum_sh_q <= tnum_sh_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      testnum_q <= testnum_d;
    end
  end

  assign done    = done_q;
  assign pass    = pass_q;
  assign testnum = testnum_q;
endmodule

// File: tb/tb_riscv_trace_monitor.sv
// Scoreboard bench: expected pops/verdicts queued by stimulus, compared by a
// monitor when the DUT pops a valid entry or raises done.
module tb_riscv_trace_monitor;
  localparam int CW = 3;

  typedef struct {
    logic [31:0] s;
    logic [31:0] d;
    logic [7:0]  r;
  } ent_t;
  typedef struct {
    logic        p;
    logic [31:0] t;
  } ver_t;

  logic clk = 1'b0, rst = 1'b1;
  logic jump_en = 1'b0, wb_en = 1'b0, tr_pop = 1'b0;
  logic [31:0] jump_src = '0, jump_dst = '0, wb_data = '0;
  logic [4:0]  wb_addr = '0;

  logic tr_valid, done, pass, w0_valid, w0_done, w0_pass;
  logic [31:0] tr_src, tr_dst, testnum, w0_src, w0_dst, w0_testnum;
  logic [7:0]  tr_rpt, w0_rpt;
  logic [CW-1:0] tr_count, w0_count;
  logic [15:0] ovf_count, w0_ovf;

  int n_vec = 0, n_err = 0;
  ent_t exp_q[$];
  ver_t exp_v[$];
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  riscv_trace_monitor #(.XLEN(32), .DEPTH(4), .WRAP(1)) u_dut (
    .clk(clk), .rst(rst), .jump_en(jump_en), .jump_src(jump_src), .jump_dst(jump_dst),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .tr_pop(tr_pop),
    .tr_valid(tr_valid), .tr_src(tr_src), .tr_dst(tr_dst), .tr_rpt(tr_rpt),
    .tr_count(tr_count), .ovf_count(ovf_count), .done(done), .pass(pass), .testnum(testnum));

  riscv_trace_monitor #(.XLEN(32), .DEPTH(4), .WRAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .jump_en(jump_en), .jump_src(jump_src), .jump_dst(jump_dst),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .tr_pop(tr_pop),
    .tr_valid(w0_valid), .tr_src(w0_src), .tr_dst(w0_dst), .tr_rpt(w0_rpt),
    .tr_count(w0_count), .ovf_count(w0_ovf), .done(w0_done), .pass(w0_pass), .testnum(w0_testnum));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (tr_pop && tr_valid) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
        else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("pop_src", tr_src, e.s);
          chk("pop_dst", tr_dst, e.d);
          chk("pop_rpt", {24'd0, tr_rpt}, {24'd0, e.r});
        end
      end
      if (done && !done_prev) begin
        if (exp_v.size() == 0) chk("verdict_unexpected", 32'd1, 32'd0);
        else begin
          ver_t v;
          v = exp_v.pop_front();
          chk("verdict_pass", {31'd0, pass}, {31'd0, v.p});
          chk("verdict_testnum", testnum, v.t);
        end
      end
    end
    done_prev = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [31:0] s, input logic [31:0] d, input logic p);
    jump_en = 1'b1; jump_src = s; jump_dst = d; tr_pop = p;
    tick();
    jump_en = 1'b0; tr_pop = 1'b0;
  endtask

  task automatic pop_exp(input logic [31:0] s, input logic [31:0] d, input logic [7:0] r);
    ent_t e;
    e.s = s; e.d = d; e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic pop1();
    tr_pop = 1'b1;
    tick();
    tr_pop = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic exp_verdict(input logic p, input logic [31:0] t);
    ver_t v;
    v.p = p; v.t = t;
    exp_v.push_back(v);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 20) begin tick(); k++; end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic async_reset(input string nm);
    rst = 1'b1;
    #1;
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
    chk({nm, "_pass"}, {31'd0, pass}, 32'd0);
    chk({nm, "_testnum"}, testnum, 32'd0);
    chk({nm, "_count"}, {29'd0, tr_count}, 32'd0);
    #3 rst = 1'b0;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_valid", {31'd0, tr_valid}, 32'd0);
    chk("rst_count", {29'd0, tr_count}, 32'd0);
    chk("rst_ovf", {16'd0, ovf_count}, 32'd0);
    chk("rst_src", tr_src, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_testnum", testnum, 32'd0);
    rst = 1'b0;
    tick();

    // basic capture
    jump(32'h10, 32'h40, 1'b0);
    jump(32'h48, 32'h10, 1'b0);
    jump(32'h20, 32'h80, 1'b0);
    chk("basic_count3", {29'd0, tr_count}, 32'd3);
    pop_exp(32'h10, 32'h40, 8'd0);
    pop_exp(32'h48, 32'h10, 8'd0);
    pop_exp(32'h20, 32'h80, 8'd0);
    pop1(); chk("basic_count2", {29'd0, tr_count}, 32'd2);
    pop1(); chk("basic_count1", {29'd0, tr_count}, 32'd1);
    pop1(); chk("basic_count0", {29'd0, tr_count}, 32'd0);
    chk("basic_ovf", {16'd0, ovf_count}, 32'd0);
    pop1(); chk("pop_empty_count", {29'd0, tr_count}, 32'd0);

    // loop compression: 256 fill the first entry, 44 more go to a second
    for (int i = 0; i < 300; i++) jump(32'h30, 32'h20, 1'b0);
    chk("loop_count", {29'd0, tr_count}, 32'd2);
    chk("loop_rpt_head", {24'd0, tr_rpt}, 32'd255);
    pop_exp(32'h30, 32'h20, 8'd255);
    pop_exp(32'h30, 32'h20, 8'd43);
    pop1(); pop1();

    // full buffer, both wrap modes
    for (int i = 0; i < 6; i++) jump(32'h100 + 32'(i * 4), 32'h200 + 32'(i * 4), 1'b0);
    chk("wrap1_head", tr_src, 32'h108);
    chk("wrap1_ovf", {16'd0, ovf_count}, 32'd2);
    chk("wrap0_head", w0_src, 32'h100);
    chk("wrap0_ovf", {16'd0, w0_ovf}, 32'd2);
    chk("wrap0_count", {29'd0, w0_count}, 32'd4);
    pop_exp(32'h108, 32'h208, 8'd0);
    jump(32'h400, 32'h500, 1'b1);
    chk("pp_count", {29'd0, tr_count}, 32'd4);
    chk("pp_ovf", {16'd0, ovf_count}, 32'd2);
    chk("pp_w0_count", {29'd0, w0_count}, 32'd4);
    chk("pp_w0_head", w0_src, 32'h104);
    pop_exp(32'h10c, 32'h20c, 8'd0);
    pop_exp(32'h110, 32'h210, 8'd0);
    pop_exp(32'h114, 32'h214, 8'd0);
    pop_exp(32'h400, 32'h500, 8'd0);
    repeat (4) pop1();
    chk("drain_count", {29'd0, tr_count}, 32'd0);

    // pass verdict with exact latency
    wb(5'd3, 32'd5);
    wb(5'd27, 32'd1);
    exp_verdict(1'b1, 32'd5);
    wb(5'd26, 32'd1);
    tick(); chk("lat_e1", {31'd0, done}, 32'd0);
    tick(); chk("lat_e2", {31'd0, done}, 32'd0);
    tick(); chk("lat_e3", {31'd0, done}, 32'd0);
    tick(); chk("lat_e4", {31'd0, done}, 32'd1);
    tick();
    jump(32'h900, 32'h904, 1'b0);
    chk("frozen_count", {29'd0, tr_count}, 32'd0);
    async_reset("rst_after_pass");

    // late pass write in the final settle cycle
    wb(5'd27, 32'd0);
    wb(5'd3, 32'd7);
    exp_verdict(1'b1, 32'd7);
    wb(5'd26, 32'd1);
    tick(); tick();
    wb(5'd27, 32'd1);
    wait_done();
    async_reset("rst_after_late");

    // fail verdict
    wb(5'd27, 32'd0);
    wb(5'd3, 32'd7);
    exp_verdict(1'b0, 32'd7);
    wb(5'd26, 32'd1);
    wait_done();
    chk("fail_done", {31'd0, done}, 32'd1);
    async_reset("rst_after_fail");

    // reset mid-settle, then a done-write of 2 is ignored, then a clean pass
    jump(32'h600, 32'h700, 1'b0);
    wb(5'd27, 32'd1);
    wb(5'd26, 32'd1);
    tick();
    async_reset("rst_mid_settle");
    wb(5'd26, 32'd2);
    repeat (6) tick();
    chk("done_ignore2", {31'd0, done}, 32'd0);
    wb(5'd3, 32'd2);
    wb(5'd27, 32'd1);
    exp_verdict(1'b1, 32'd2);
    wb(5'd26, 32'd1);
    wait_done();

    chk("sb_leftover", 32'(exp_q.size() + exp_v.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
